// File: rtl/call_loop_sequencer.sv
// Program sequencer: fetch-address generation with jumps, a call/return stack and
// an optional single-level zero-overhead loop (compiled in when SEQ_HW_LOOP_EN is defined).
module call_loop_sequencer #(
    parameter int PC_W        = 8,
    parameter int STACK_DEPTH = 4,
    parameter int LOOP_W      = 4
) (
    input  logic                               clk,
    input  logic                               reset,
    input  logic                               stall,
    input  logic                               jmp,
    input  logic                               jmp_nz,
    input  logic                               dont_jmp,
    input  logic                               call,
    input  logic                               ret,
    input  logic                               loop_start,
    input  logic [LOOP_W-1:0]                  loop_count,
    input  logic [PC_W-1:0]                    jmp_addr,
    output logic [PC_W-1:0]                    pm_addr,
    output logic [PC_W-1:0]                    pc,
    output logic [$clog2(STACK_DEPTH+1)-1:0]   sp,
    output logic                               stack_full,
    output logic                               stack_empty,
    output logic                               stack_err,
    output logic                               loop_active,
    output logic                               loop_err
);

    localparam int SP_W  = $clog2(STACK_DEPTH + 1);
    localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

    logic [PC_W-1:0]  stack_mem [STACK_DEPTH];
    logic [PC_W-1:0]  pc_inc;
    logic [IDX_W-1:0] top_idx;
    logic [IDX_W-1:0] push_idx;
    logic             push;
    logic             pop;
    logic             set_serr;

`ifdef SEQ_HW_LOOP_EN
    logic [PC_W-1:0]   loop_begin;
    logic [PC_W-1:0]   loop_end;
    logic [LOOP_W-1:0] loop_rem;
    logic              loop_arm;
    logic              loop_dec;
    logic              loop_clr;
    logic              set_lerr;
`else
    logic unused_loop;
    assign unused_loop = ^{loop_start, loop_count};
    assign loop_active = 1'b0;
    assign loop_err    = 1'b0;
`endif

    assign pc_inc      = pc + PC_W'(1);
    assign top_idx     = IDX_W'(sp - SP_W'(1));
    assign push_idx    = IDX_W'(sp);
    assign stack_full  = (sp == SP_W'(STACK_DEPTH));
    assign stack_empty = (sp == '0);

    // While reset is held the fetch address is forced to 0 regardless of controls.
    always_comb begin
        pm_addr  = pc_inc;
        push     = 1'b0;
        pop      = 1'b0;
        set_serr = 1'b0;
`ifdef SEQ_HW_LOOP_EN
        loop_arm = 1'b0;
        loop_dec = 1'b0;
        loop_clr = 1'b0;
        set_lerr = 1'b0;
`endif
        if (!reset) begin
            pm_addr = '0;
        end else if (stall) begin
            pm_addr = pc;
        end else if (ret) begin
            if (!stack_empty) begin
                pm_addr = stack_mem[top_idx];
                pop     = 1'b1;
            end else begin
                set_serr = 1'b1;
            end
        end else if (call) begin
            if (!stack_full) begin
                pm_addr = jmp_addr;
                push    = 1'b1;
            end else begin
                set_serr = 1'b1;
            end
        end else if (jmp || (jmp_nz && !dont_jmp)) begin
            pm_addr = jmp_addr;
`ifdef SEQ_HW_LOOP_EN
        end else if (loop_start) begin
            if (loop_active) begin
                set_lerr = 1'b1;
            end else begin
                loop_arm = 1'b1;
                if (loop_count == '0)
                    pm_addr = jmp_addr + PC_W'(1);
            end
        end else if (loop_active && (pc == loop_end)) begin
            if (loop_rem > LOOP_W'(1)) begin
                pm_addr  = loop_begin;
                loop_dec = 1'b1;
            end else begin
                loop_clr = 1'b1;
            end
`endif
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            pc        <= '1;
            sp        <= '0;
            stack_err <= 1'b0;
        end else begin
            pc <= pm_addr;
            if (push)
                sp <= sp + SP_W'(1);
            else if (pop)
                sp <= sp - SP_W'(1);
            if (set_serr)
                stack_err <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (push)
            stack_mem[push_idx] <= pc_inc;
    end

`ifdef SEQ_HW_LOOP_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            loop_begin  <= '0;
            loop_end    <= '0;
            loop_rem    <= '0;
            loop_active <= 1'b0;
            loop_err    <= 1'b0;
        end else begin
            if (loop_arm) begin
                loop_begin  <= pc_inc;
                loop_end    <= jmp_addr;
                loop_rem    <= loop_count;
                loop_active <= (loop_count != '0);
            end
            if (loop_dec)
                loop_rem <= loop_rem - LOOP_W'(1);
            if (loop_clr)
                loop_active <= 1'b0;
            if (set_lerr)
                loop_err <= 1'b1;
        end
    end
`endif

endmodule

// File: doc/call_loop_sequencer.md
# call_loop_sequencer

Parametrised next-generation program sequencer for the microprocessor core. It generates the program-memory fetch address each cycle and supports the existing jump and conditional-jump controls. It adds a subroutine call/return stack of configurable depth and a single-level zero-overhead hardware loop. It sits between the instruction decoder, which supplies the control strobes and target address, and the program memory, which it drives through `pm_addr`.

## Interface
- `PC_W`, 8: program-counter and program-memory address width.
- `STACK_DEPTH`, 4: number of return-address entries (≥1).
- `LOOP_W`, 4: loop iteration counter width.

- `clk` in 1: clock; all state updates on its rising edge.
- `reset` in 1: asynchronous, active-low reset.
- `stall` in 1: hold the current address; no state change.
- `jmp` in 1: unconditional jump to `jmp_addr`.
- `jmp_nz` in 1: conditional jump to `jmp_addr` when `dont_jmp`=0.
- `dont_jmp` in 1: zero flag from the computational unit.
- `call` in 1: push the return address and jump to `jmp_addr`.
- `ret` in 1: pop the top of stack into `pm_addr`.
- `loop_start` in 1: arm the hardware loop; end address is `jmp_addr`.
- `loop_count` in `LOOP_W`: number of body iterations.
- `jmp_addr` in `PC_W`: target, call, or loop-end address.
- `pm_addr` out `PC_W`: combinational fetch address.
- `pc` out `PC_W`: registered, equals the previous cycle's `pm_addr`.
- `sp` out `$clog2(STACK_DEPTH+1)`: stack occupancy.
- `stack_full`, `stack_empty` out 1: `sp`==`STACK_DEPTH`, `sp`==0.
- `stack_err` out 1: sticky overflow/underflow flag.
- `loop_active` out 1: hardware loop armed.
- `loop_err` out 1: sticky flag, set on `loop_start` while a loop is active.

## Operation
**Reset values** (reset low, asynchronous):
- `pc` = all ones, so `pm_addr` = `pc`+1 wraps to 0.
- `sp` = 0, `stack_err` = 0, `loop_active` = 0, `loop_err` = 0.
- Loop count and loop registers cleared.
- The first fetch after release is address 0.

**Next-address selection.** `pm_addr` is selected by the first matching rule, highest priority first:
1. `stall` gives `pc` (hold). No register changes.
2. `ret` with `sp`>0 gives top of stack; `sp` decrements. `ret` with `sp`=0 gives `pc`+1 and sets `stack_err`.
3. `call` with `sp`<`STACK_DEPTH` pushes `pc`+1 and gives `jmp_addr`; `sp` increments. `call` when full gives `pc`+1, does not push, and sets `stack_err`.
4. `jmp` gives `jmp_addr`.
5. `jmp_nz` with `dont_jmp`=0 gives `jmp_addr`.
6. `loop_start` captures `loop_begin`=`pc`+1, `loop_end`=`jmp_addr`, remaining=`loop_count`, and sets `loop_active`. It gives `pc`+1. If `loop_count`=0, it gives `jmp_addr`+1 and `loop_active` stays 0. If a loop is already active, `loop_start` is ignored (gives `pc`+1) and sets `loop_err`.
7. Loop-back: `loop_active` and `pc`==`loop_end`. If remaining>1, gives `loop_begin` and remaining decrements. If remaining==1, gives `pc`+1 and clears `loop_active`.
8. Otherwise gives `pc`+1.

**Simultaneous events.**
- `ret` and `call` together: `ret` wins and `call` is dropped.
- A jump or call taken at `loop_end` suppresses the loop-back for that cycle. The loop stays armed.
- A `ret` or `call` landing on `loop_end` still triggers loop-back on the next cycle.

**Arithmetic.** All address arithmetic is modulo 2^`PC_W`; `pc`+1 wraps from all ones to 0.

**Error flags.** `stack_err` and `loop_err` clear only on reset.

**Stack storage.** Stack entries are not reset; only `sp` is reset.

## Timing
- `pm_addr` is combinational from the registered state and the current control inputs. The decoder drives those controls in the same cycle.
- `pc`, `sp`, the stack, and the loop registers update on the rising edge of `clk`.
- Latency: the control input is applied in the same cycle as `pm_addr`; `pc` reflects it one edge later.
- Reset asserted mid-loop or mid-call aborts immediately. After release, the first fetch is from 0 with an empty stack.

## Configuration
- `SEQ_HW_LOOP_EN` defined: hardware loop logic (rules 6–7, `loop_active`, `loop_err`) is compiled in.
- `SEQ_HW_LOOP_EN` undefined: `loop_start` and `loop_count` are ignored (rule 6 gives `pc`+1). `loop_active` and `loop_err` are tied to 0. No loop registers are inferred. Ports are unchanged.

## Test plan
- **Reset:** hold reset low 3 cycles with `jmp`=1 → `pc`=FF and `pm_addr`=00. Release with no controls → `pm_addr` goes 00, 01, 02 on consecutive cycles.
- **Jumps:** at `pc`=05, assert `jmp_nz` with `jmp_addr`=20 and `dont_jmp`=1 → `pm_addr`=06. Repeat with `dont_jmp`=0 → `pm_addr`=20. At `pc`=FF, no controls → `pm_addr`=00 (wrap).
- **Call/return:** nest 4 calls from `pc`=10, 30, 50, 70 → `sp`=4 and `stack_full`=1. A 5th call → `pm_addr`=`pc`+1 and `stack_err`=1. Four `ret`s return 71, 51, 31, 11. A 5th `ret` leaves `sp`=0 with `stack_err` still 1.
- **Hardware loop:** at `pc`=08, `loop_start` with `jmp_addr`=0A and `loop_count`=3 → address sequence 09, 0A, 09, 0A, 09, 0A, 0B, then `loop_active`=0. With `loop_count`=0 → next `pm_addr`=0B.
- **Stall and priority:** `stall` with `ret` asserted at `pc`=0A inside an active loop → `pm_addr`=0A, and `sp` and remaining are unchanged. Assert `call` and `ret` together → a pop occurs and no push.
- **Reset mid-operation:** pulse reset low between edges while `sp`=2 and a loop is active → `pm_addr`=00, `sp`=0, `loop_active`=0 immediately, without waiting for `clk`.
